// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared constants for the ALU reservation station
package alu_rs_pkg;

  // Datapath widths
  localparam int ROB_W  = 5;
  localparam int XLEN   = 32;
  localparam int TYPE_W = 7;
  localparam int OP_W   = 4;

  // Major opcodes routed to this station
  localparam logic [TYPE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [TYPE_W-1:0] OP_I    = 7'b0010011;
  localparam logic [TYPE_W-1:0] OP_B    = 7'b1100011;
  localparam logic [TYPE_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [TYPE_W-1:0] OP_JALR = 7'b1100111;

  // ALU operation encodings carried in the op field
  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, CDB snoop and ALU issue bundle for the reservation station
interface alu_rs_if #(
  parameter int ROB_W = alu_rs_pkg::ROB_W
);
  import alu_rs_pkg::*;

  // Flush
  logic              clear;

  // Dispatch
  logic              dp_valid;
  logic [ROB_W-1:0]  dp_rob_id;
  logic [TYPE_W-1:0] dp_type;
  logic [OP_W-1:0]   dp_op;
  logic              dp_qj_busy;
  logic              dp_qk_busy;
  logic [ROB_W-1:0]  dp_qj;
  logic [ROB_W-1:0]  dp_qk;
  logic [XLEN-1:0]   dp_vj;
  logic [XLEN-1:0]   dp_vk;
  logic              rs_full;

  // Result broadcast buses
  logic              cdb_alu_ready;
  logic [ROB_W-1:0]  cdb_alu_rob_id;
  logic [XLEN-1:0]   cdb_alu_value;
  logic              cdb_lsb_ready;
  logic [ROB_W-1:0]  cdb_lsb_rob_id;
  logic [XLEN-1:0]   cdb_lsb_value;

  // Issue to ALU
  logic              alu_ready;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [TYPE_W-1:0] alu_type;
  logic [OP_W-1:0]   alu_op;
  logic [XLEN-1:0]   alu_v1;
  logic [XLEN-1:0]   alu_v2;

  modport master (
    output clear, dp_valid, dp_rob_id, dp_type, dp_op,
           dp_qj_busy, dp_qk_busy, dp_qj, dp_qk, dp_vj, dp_vk,
           cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value,
    input  rs_full, alu_ready, alu_rob_id, alu_type, alu_op, alu_v1, alu_v2
  );

  modport slave (
    input  clear, dp_valid, dp_rob_id, dp_type, dp_op,
           dp_qj_busy, dp_qk_busy, dp_qj, dp_qk, dp_vj, dp_vk,
           cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value,
    output rs_full, alu_ready, alu_rob_id, alu_type, alu_op, alu_v1, alu_v2
  );

endinterface

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - lowest-index find-first over a request vector
module alu_rs_pick #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding the single-cycle ALU
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = alu_rs_pkg::ROB_W
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  alu_rs_if.slave bus
);
  import alu_rs_pkg::*;

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0] valid_q;
  logic [RS_SIZE-1:0] qj_busy_q;
  logic [RS_SIZE-1:0] qk_busy_q;
  logic [ROB_W-1:0]   rob_q  [RS_SIZE];
  logic [ROB_W-1:0]   qj_q   [RS_SIZE];
  logic [ROB_W-1:0]   qk_q   [RS_SIZE];
  logic [TYPE_W-1:0]  type_q [RS_SIZE];
  logic [OP_W-1:0]    op_q   [RS_SIZE];
  logic [XLEN-1:0]    vj_q   [RS_SIZE];
  logic [XLEN-1:0]    vk_q   [RS_SIZE];

  // Scheduling
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] free_vec;
  logic               free_found;
  logic               ready_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   ready_idx;
  logic               do_issue;
  logic               do_dispatch;

  // Per-entry CDB tag hits on pending operands
  logic [RS_SIZE-1:0] j_alu_hit;
  logic [RS_SIZE-1:0] j_lsb_hit;
  logic [RS_SIZE-1:0] k_alu_hit;
  logic [RS_SIZE-1:0] k_lsb_hit;

  // Dispatched operands after same-cycle CDB bypass
  logic               dp_qj_busy_n;
  logic               dp_qk_busy_n;
  logic [XLEN-1:0]    dp_vj_n;
  logic [XLEN-1:0]    dp_vk_n;

  // Readiness only looks at registered state, so a fresh dispatch cannot issue in its own cycle.
  assign ready_vec = valid_q & ~qj_busy_q & ~qk_busy_q;
  assign free_vec  = ~valid_q;

  alu_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Every entry valid means no free slot; a slot freed by issue shows up only after the edge.
  assign bus.rs_full  = &valid_q;
  assign do_issue     = ready_found & rdy_in & ~bus.clear;
  assign bus.alu_ready = do_issue;
  assign do_dispatch  = bus.dp_valid & free_found;

  // Compare every pending operand tag against both broadcast buses.
  always_comb begin
    j_alu_hit = '0;
    j_lsb_hit = '0;
    k_alu_hit = '0;
    k_lsb_hit = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      j_alu_hit[i] = valid_q[i] & qj_busy_q[i] & bus.cdb_alu_ready & (bus.cdb_alu_rob_id == qj_q[i]);
      j_lsb_hit[i] = valid_q[i] & qj_busy_q[i] & bus.cdb_lsb_ready & (bus.cdb_lsb_rob_id == qj_q[i]);
      k_alu_hit[i] = valid_q[i] & qk_busy_q[i] & bus.cdb_alu_ready & (bus.cdb_alu_rob_id == qk_q[i]);
      k_lsb_hit[i] = valid_q[i] & qk_busy_q[i] & bus.cdb_lsb_ready & (bus.cdb_lsb_rob_id == qk_q[i]);
    end
  end

  // Resolve dispatched operands whose producer is broadcasting right now.
  always_comb begin
    dp_qj_busy_n = bus.dp_qj_busy;
    dp_vj_n      = bus.dp_vj;
    dp_qk_busy_n = bus.dp_qk_busy;
    dp_vk_n      = bus.dp_vk;
    if (bus.dp_qj_busy) begin
      if (bus.cdb_alu_ready && bus.cdb_alu_rob_id == bus.dp_qj) begin
        dp_qj_busy_n = 1'b0;
        dp_vj_n      = bus.cdb_alu_value;
      end else if (bus.cdb_lsb_ready && bus.cdb_lsb_rob_id == bus.dp_qj) begin
        dp_qj_busy_n = 1'b0;
        dp_vj_n      = bus.cdb_lsb_value;
      end
    end
    if (bus.dp_qk_busy) begin
      if (bus.cdb_alu_ready && bus.cdb_alu_rob_id == bus.dp_qk) begin
        dp_qk_busy_n = 1'b0;
        dp_vk_n      = bus.cdb_alu_value;
      end else if (bus.cdb_lsb_ready && bus.cdb_lsb_rob_id == bus.dp_qk) begin
        dp_qk_busy_n = 1'b0;
        dp_vk_n      = bus.cdb_lsb_value;
      end
    end
  end

  // Entry table: flush, wake-up, issue invalidation and dispatch write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q   <= '0;
      qj_busy_q <= '0;
      qk_busy_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        rob_q[i]  <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        type_q[i] <= '0;
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (bus.clear) begin
        valid_q <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (j_alu_hit[i]) begin
            qj_busy_q[i] <= 1'b0;
            vj_q[i]      <= bus.cdb_alu_value;
          end else if (j_lsb_hit[i]) begin
            qj_busy_q[i] <= 1'b0;
            vj_q[i]      <= bus.cdb_lsb_value;
          end
          if (k_alu_hit[i]) begin
            qk_busy_q[i] <= 1'b0;
            vk_q[i]      <= bus.cdb_alu_value;
          end else if (k_lsb_hit[i]) begin
            qk_busy_q[i] <= 1'b0;
            vk_q[i]      <= bus.cdb_lsb_value;
          end
        end
        if (do_issue) begin
          valid_q[ready_idx] <= 1'b0;
        end
        // The free slot was invalid before this edge, so it never collides with the issued one.
        if (do_dispatch) begin
          valid_q[free_idx]   <= 1'b1;
          rob_q[free_idx]     <= bus.dp_rob_id;
          type_q[free_idx]    <= bus.dp_type;
          op_q[free_idx]      <= bus.dp_op;
          qj_q[free_idx]      <= bus.dp_qj;
          qk_q[free_idx]      <= bus.dp_qk;
          qj_busy_q[free_idx] <= dp_qj_busy_n;
          qk_busy_q[free_idx] <= dp_qk_busy_n;
          vj_q[free_idx]      <= dp_vj_n;
          vk_q[free_idx]      <= dp_vk_n;
        end
      end
    end
  end

  // Issued uop registers; they hold so the ALU can compute during the following cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.alu_rob_id <= '0;
      bus.alu_type   <= '0;
      bus.alu_op     <= '0;
      bus.alu_v1     <= '0;
      bus.alu_v2     <= '0;
    end else if (rdy_in) begin
      if (bus.clear) begin
        bus.alu_rob_id <= '0;
        bus.alu_type   <= '0;
        bus.alu_op     <= '0;
        bus.alu_v1     <= '0;
        bus.alu_v2     <= '0;
      end else if (do_issue) begin
        bus.alu_rob_id <= rob_q[ready_idx];
        bus.alu_type   <= type_q[ready_idx];
        bus.alu_op     <= op_q[ready_idx];
        bus.alu_v1     <= vj_q[ready_idx];
        bus.alu_v2     <= vk_q[ready_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - self-checking bench for the ALU reservation station
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  alu_rs_if bus ();

  alu_rs dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a slot table plus the issued-uop registers
  typedef struct {
    bit          valid;
    logic [4:0]  rob;
    logic [6:0]  typ;
    logic [3:0]  op;
    bit          jb;
    logic [4:0]  qj;
    logic [31:0] vj;
    bit          kb;
    logic [4:0]  qk;
    logic [31:0] vk;
  } ment_t;

  ment_t       m [8];
  logic [4:0]  e_rob;
  logic [6:0]  e_type;
  logic [3:0]  e_op;
  logic [31:0] e_v1;
  logic [31:0] e_v2;

  typedef struct {
    logic [4:0]  rob;
    logic [6:0]  typ;
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] res;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int first_ready();
    int r = -1;
    for (int i = 0; i < 8; i++) if (r < 0 && m[i].valid && !m[i].jb && !m[i].kb) r = i;
    return r;
  endfunction

  function automatic int first_free();
    int r = -1;
    for (int i = 0; i < 8; i++) if (r < 0 && !m[i].valid) r = i;
    return r;
  endfunction

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < 8; i++) if (!m[i].valid) f = 1'b0;
    return f;
  endfunction

  // Resolve pending operands from whatever the buses broadcast this cycle.
  function automatic ment_t capture(input ment_t e);
    ment_t r = e;
    if (r.jb && bus.cdb_alu_ready && bus.cdb_alu_rob_id == r.qj) begin r.jb = 0; r.vj = bus.cdb_alu_value; end
    if (r.jb && bus.cdb_lsb_ready && bus.cdb_lsb_rob_id == r.qj) begin r.jb = 0; r.vj = bus.cdb_lsb_value; end
    if (r.kb && bus.cdb_alu_ready && bus.cdb_alu_rob_id == r.qk) begin r.kb = 0; r.vk = bus.cdb_alu_value; end
    if (r.kb && bus.cdb_lsb_ready && bus.cdb_lsb_rob_id == r.qk) begin r.kb = 0; r.vk = bus.cdb_lsb_value; end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m[i].valid = 1'b0;
    e_rob = '0; e_type = '0; e_op = '0; e_v1 = '0; e_v2 = '0;
  endtask

  task automatic set_idle();
    bus.clear = 1'b0;
    bus.dp_valid = 1'b0; bus.dp_rob_id = '0; bus.dp_type = '0; bus.dp_op = '0;
    bus.dp_qj_busy = 1'b0; bus.dp_qk_busy = 1'b0; bus.dp_qj = '0; bus.dp_qk = '0;
    bus.dp_vj = '0; bus.dp_vk = '0;
    bus.cdb_alu_ready = 1'b0; bus.cdb_alu_rob_id = '0; bus.cdb_alu_value = '0;
    bus.cdb_lsb_ready = 1'b0; bus.cdb_lsb_rob_id = '0; bus.cdb_lsb_value = '0;
  endtask

  task automatic set_dp(input logic [4:0] rob, input logic [6:0] typ, input logic [3:0] op,
                        input bit jb, input logic [4:0] qj, input logic [31:0] vj,
                        input bit kb, input logic [4:0] qk, input logic [31:0] vk);
    bus.dp_valid = 1'b1; bus.dp_rob_id = rob; bus.dp_type = typ; bus.dp_op = op;
    bus.dp_qj_busy = jb; bus.dp_qj = qj; bus.dp_vj = vj;
    bus.dp_qk_busy = kb; bus.dp_qk = qk; bus.dp_vk = vk;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registered outputs.
  task automatic tick();
    bit    er;
    int    ri;
    int    fi;
    ment_t ne;
    #1;
    er = rdy_in && !bus.clear && (first_ready() >= 0);
    chk("alu_ready", 32'(bus.alu_ready), 32'(er));
    chk("rs_full", 32'(bus.rs_full), 32'(m_full()));
    @(posedge clk_in);
    if (rdy_in) begin
      if (bus.clear) begin
        model_clear();
      end else begin
        ri = first_ready();
        fi = first_free();
        if (ri >= 0) begin
          e_rob = m[ri].rob; e_type = m[ri].typ; e_op = m[ri].op; e_v1 = m[ri].vj; e_v2 = m[ri].vk;
          m[ri].valid = 1'b0;
        end
        for (int i = 0; i < 8; i++) if (m[i].valid) m[i] = capture(m[i]);
        if (bus.dp_valid && fi >= 0) begin
          ne.valid = 1'b1; ne.rob = bus.dp_rob_id; ne.typ = bus.dp_type; ne.op = bus.dp_op;
          ne.jb = bus.dp_qj_busy; ne.qj = bus.dp_qj; ne.vj = bus.dp_vj;
          ne.kb = bus.dp_qk_busy; ne.qk = bus.dp_qk; ne.vk = bus.dp_vk;
          m[fi] = capture(ne);
        end
      end
    end
    #1;
    chk("alu_rob_id", 32'(bus.alu_rob_id), 32'(e_rob));
    chk("alu_type", 32'(bus.alu_type), 32'(e_type));
    chk("alu_op", 32'(bus.alu_op), 32'(e_op));
    chk("alu_v1", bus.alu_v1, e_v1);
    chk("alu_v2", bus.alu_v2, e_v2);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #1;
    model_clear();
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_rs_full", 32'(bus.rs_full), 32'd0);
    chk("rst_alu_rob_id", 32'(bus.alu_rob_id), 32'd0);
    chk("rst_alu_type", 32'(bus.alu_type), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_alu_v1", bus.alu_v1, 32'd0);
    chk("rst_alu_v2", bus.alu_v2, 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    logic [4:0] ta;
    vt[0] = '{5'd1, OP_R,   ALU_ADD,  32'd3,        32'd4,      32'd7};
    vt[1] = '{5'd2, OP_R,   ALU_SUB,  32'd10,       32'd3,      32'd7};
    vt[2] = '{5'd3, OP_I,   ALU_AND,  32'h0000F0F0, 32'hFF00,   32'h0000F000};
    vt[3] = '{5'd4, OP_R,   ALU_SLT,  32'hFFFFFFFF, 32'd1,      32'd1};
    vt[4] = '{5'd5, OP_R,   ALU_SLTU, 32'hFFFFFFFF, 32'd1,      32'd0};
    vt[5] = '{5'd6, OP_I,   ALU_SRA,  32'h80000000, 32'd4,      32'hF8000000};
    vt[6] = '{5'd7, OP_B,   ALU_SUB,  32'd5,        32'd5,      32'd0};
    vt[7] = '{5'd8, OP_JAL, ALU_ADD,  32'h1000,     32'd4,      32'h1004};

    set_idle();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    model_clear();
    @(negedge clk_in);
    do_reset();

    // Table: independent uops issue the cycle after dispatch; ALU computes from held registers.
    for (int v = 0; v < 8; v++) begin
      set_idle();
      set_dp(vt[v].rob, vt[v].typ, vt[v].op, 1'b0, 5'd0, vt[v].vj, 1'b0, 5'd0, vt[v].vk);
      tick();
      set_idle();
      #1;
      chk("vec_issue_strobe", 32'(bus.alu_ready), 32'd1);
      tick();
      chk("vec_v1", bus.alu_v1, vt[v].vj);
      chk("vec_v2", bus.alu_v2, vt[v].vk);
      chk("vec_rob", 32'(bus.alu_rob_id), 32'(vt[v].rob));
      chk("vec_result", alu_fn(bus.alu_op, bus.alu_v1, bus.alu_v2), vt[v].res);
    end

    // Reset while three entries wait on tag 20; nothing may issue afterwards.
    for (int i = 0; i < 3; i++) begin
      set_idle();
      set_dp(5'(16 + i), OP_R, ALU_ADD, 1'b1, 5'd20, 32'd0, 1'b0, 5'd0, 32'd1);
      tick();
    end
    set_idle();
    do_reset();
    bus.cdb_lsb_ready = 1'b1; bus.cdb_lsb_rob_id = 5'd20; bus.cdb_lsb_value = 32'h55;
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_reset_no_issue", 32'(bus.alu_ready), 32'd0);
      tick();
    end

    // Operand j waits for LSB tag 5, broadcast two cycles after dispatch.
    set_idle();
    set_dp(5'd3, OP_I, ALU_ADD, 1'b1, 5'd5, 32'd0, 1'b0, 5'd0, 32'd1);
    tick();
    set_idle();
    tick();
    bus.cdb_lsb_ready = 1'b1; bus.cdb_lsb_rob_id = 5'd5; bus.cdb_lsb_value = 32'h10;
    #1;
    chk("wake_not_before_edge", 32'(bus.alu_ready), 32'd0);
    tick();
    set_idle();
    #1;
    chk("wake_issue_next", 32'(bus.alu_ready), 32'd1);
    tick();
    chk("wake_v1", bus.alu_v1, 32'h10);

    // Operand k bypassed from the ALU CDB in the dispatch cycle.
    set_idle();
    set_dp(5'd4, OP_R, ALU_OR, 1'b0, 5'd0, 32'd2, 1'b1, 5'd9, 32'd0);
    bus.cdb_alu_ready = 1'b1; bus.cdb_alu_rob_id = 5'd9; bus.cdb_alu_value = 32'hAB;
    tick();
    set_idle();
    #1;
    chk("bypass_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    chk("bypass_v2", bus.alu_v2, 32'hAB);

    // Fill all entries on tag 2, then release them together.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_dp(5'(8 + i), OP_R, ALU_ADD, 1'b1, 5'd2, 32'd0, 1'b0, 5'd0, 32'(i));
      tick();
    end
    set_idle();
    #1;
    chk("full_after_8", 32'(bus.rs_full), 32'd1);
    set_dp(5'd31, OP_R, ALU_ADD, 1'b0, 5'd0, 32'd9, 1'b0, 5'd0, 32'd9);
    bus.cdb_lsb_ready = 1'b1; bus.cdb_lsb_rob_id = 5'd2; bus.cdb_lsb_value = 32'h77;
    tick();
    set_idle();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("burst_strobe", 32'(bus.alu_ready), 32'd1);
      if (k == 0) chk("full_before_first_issue", 32'(bus.rs_full), 32'd1);
      if (k == 1) chk("full_drops_after_issue", 32'(bus.rs_full), 32'd0);
      tick();
      chk("burst_order", 32'(bus.alu_rob_id), 32'(8 + k));
      chk("burst_v1", bus.alu_v1, 32'h77);
    end
    #1;
    chk("burst_done", 32'(bus.alu_ready), 32'd0);

    // Freeze with a ready entry, then flush.
    set_idle();
    set_dp(5'd6, OP_R, ALU_XOR, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2);
    tick();
    rdy_in = 1'b0;
    set_dp(5'd12, OP_R, ALU_ADD, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd6);
    #1;
    chk("frozen_no_strobe", 32'(bus.alu_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("frozen_hold_rob", 32'(bus.alu_rob_id), 32'd15);
    rdy_in = 1'b1;
    bus.clear = 1'b1;
    #1;
    chk("clear_no_strobe", 32'(bus.alu_ready), 32'd0);
    tick();
    chk("clear_zero_rob", 32'(bus.alu_rob_id), 32'd0);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_clear_no_issue", 32'(bus.alu_ready), 32'd0);
      tick();
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_idle();
      rdy_in = ($urandom_range(0, 7) != 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      if (!m_full() && $urandom_range(0, 1) == 1)
        set_dp(5'($urandom_range(0, 31)), OP_R, 4'($urandom_range(0, 9)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      ta = 5'($urandom_range(0, 7));
      bus.cdb_alu_ready = 1'($urandom_range(0, 1));
      bus.cdb_alu_rob_id = ta;
      bus.cdb_alu_value = $urandom;
      bus.cdb_lsb_ready = 1'($urandom_range(0, 1));
      bus.cdb_lsb_rob_id = (ta + 5'($urandom_range(1, 7))) & 5'd7;
      bus.cdb_lsb_value = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
